// File: rtl/pipeline_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//   Bundles the hazard-unit view of the 5-stage RV32I pipeline: register
//   specifiers and control bits coming from each stage, the data-memory
//   handshake, and the stall/flush/forwarding controls going back.
//   master : the pipeline datapath (drives stage info, consumes controls)
//   slave  : the hazard controller (consumes stage info, drives controls)
// ----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;

    // Register specifiers per stage
    logic [4:0] rs1_D;
    logic [4:0] rs2_D;
    logic [4:0] rs1_E;
    logic [4:0] rs2_E;
    logic [4:0] rd_E;
    logic [4:0] rd_M;
    logic [4:0] rd_W;

    // Stage control bits
    logic       ctrl_result_E;
    logic       ctrl_register_file_WE_M;
    logic       ctrl_register_file_WE_W;
    logic       branch_taken_E;

    // Data-memory handshake
    logic       dmem_req_M;
    logic       dmem_ready;

    // Pipeline controls
    logic       stall_F;
    logic       stall_D;
    logic       stall_E;
    logic       stall_M;
    logic       flush_D;
    logic       flush_E;
    logic       bubble_W;
    logic [1:0] fwd_a_E;
    logic [1:0] fwd_b_E;
    logic       mem_err;

    modport master (
        output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
        output ctrl_result_E, ctrl_register_file_WE_M, ctrl_register_file_WE_W,
        output branch_taken_E, dmem_req_M, dmem_ready,
        input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W,
        input  fwd_a_E, fwd_b_E, mem_err
    );

    modport slave (
        input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
        input  ctrl_result_E, ctrl_register_file_WE_M, ctrl_register_file_WE_W,
        input  branch_taken_E, dmem_req_M, dmem_ready,
        output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W,
        output fwd_a_E, fwd_b_E, mem_err
    );

endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Hazard/sequencing controller for the 5-stage RV32I pipeline.
//   - EX-stage operand forwarding selects (MEM result beats WB result).
//   - Load-use stall, taken-branch flush.
//   - Multi-cycle data memory: freezes the whole pipe while the access is
//     outstanding; after MAX_WAIT consecutive wait cycles it enters a sticky
//     error state that only rst_n leaves.
//   Optional feature macro: STALL_COUNTERS_EN adds saturating performance
//   counters perf_lw_stalls / perf_mem_wait / perf_flushes (CNT_W bits).
//   Reset: synchronous, active-low rst_n.
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave hz
`ifdef STALL_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]      perf_lw_stalls,
    output logic [CNT_W-1:0]      perf_mem_wait,
    output logic [CNT_W-1:0]      perf_flushes
`endif
);

    // Forwarding select encodings
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

    // Wait counter only ever reaches MAX_WAIT-1 before the error state,
    // so this width can never wrap.
    localparam int                 WCNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0]  LAST_WAIT = WCNT_W'(MAX_WAIT - 1);

    // Reject nonsensical configurations at elaboration time.
    generate
        if (MAX_WAIT < 1 || CNT_W < 1) begin : g_bad_params
            $error("pipeline_hazard_ctrl: MAX_WAIT and CNT_W must both be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_e;

    state_e            state;
    state_e            eff_state;
    logic [WCNT_W-1:0] wait_cnt;

    logic mem_stall;
    logic lw_stall;
    logic apply_freeze;
    logic apply_branch;
    logic apply_lw;

    // ------------------------------------------------------------------
    // Forwarding: a producer in MEM is younger than one in WB, so it wins.
    // x0 is never forwarded because it is hardwired to zero.
    // ------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       we_m,
        input logic [4:0] rd_m,
        input logic       we_w,
        input logic [4:0] rd_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    // Forwarding selects for both EX operands, independent of FSM state
    always_comb begin
        hz.fwd_a_E = fwd_sel(hz.rs1_E, hz.ctrl_register_file_WE_M, hz.rd_M,
                             hz.ctrl_register_file_WE_W, hz.rd_W);
        hz.fwd_b_E = fwd_sel(hz.rs2_E, hz.ctrl_register_file_WE_M, hz.rd_M,
                             hz.ctrl_register_file_WE_W, hz.rd_W);
    end

    // ------------------------------------------------------------------
    // Hazard detection and priority resolution.
    // While rst_n is low the registered state may still be WAIT/ERR until
    // the reset edge; the controls must already behave as in RUN.
    // ------------------------------------------------------------------
    assign eff_state = rst_n ? state : RUN;

    assign mem_stall = (eff_state == RUN || eff_state == WAIT)
                       && hz.dmem_req_M && !hz.dmem_ready;

    assign lw_stall  = hz.ctrl_result_E && (hz.rd_E != 5'd0)
                       && ((hz.rd_E == hz.rs1_D) || (hz.rd_E == hz.rs2_D));

    // Post-priority view: ERR > mem_stall > branch > load-use
    assign apply_freeze = (eff_state == ERR) || mem_stall;
    assign apply_branch = !apply_freeze && hz.branch_taken_E;
    assign apply_lw     = !apply_freeze && !hz.branch_taken_E && lw_stall;

    // Drive stall/flush/bubble controls from the resolved hazard
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        hz.stall_F  = 1'b0;
        hz.stall_D  = 1'b0;
        hz.stall_E  = 1'b0;
        hz.stall_M  = 1'b0;
        hz.flush_D  = 1'b0;
        hz.flush_E  = 1'b0;
        hz.bubble_W = 1'b0;
        if (apply_freeze) begin
            // Whole pipe holds; the instruction leaving MEM must not write back twice.
            hz.stall_F  = 1'b1;
            hz.stall_D  = 1'b1;
            hz.stall_E  = 1'b1;
            hz.stall_M  = 1'b1;
            hz.bubble_W = 1'b1;
        end else if (apply_branch) begin
            // Wrong-path instructions in IF/ID and ID/EX are discarded.
            hz.flush_D = 1'b1;
            hz.flush_E = 1'b1;
        end else if (apply_lw) begin
            // Hold fetch/decode one cycle and insert a bubble into EX; the
            // bubble clears ctrl_result_E, so the stall lasts exactly one cycle.
            hz.stall_F = 1'b1;
            hz.stall_D = 1'b1;
            hz.flush_E = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Memory-wait FSM: counts consecutive wait cycles (the first stalled
    // cycle in RUN counts as one) and traps into ERR on timeout.
    // ------------------------------------------------------------------
    // State, wait counter and sticky error flag
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            hz.mem_err <= 1'b0;
        end else begin
            case (state)
                RUN, WAIT: begin
                    if (mem_stall) begin
                        if (wait_cnt == LAST_WAIT) begin
                            state      <= ERR;
                            hz.mem_err <= 1'b1;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= wait_cnt + WCNT_W'(1);
                        end
                    end else begin
                        // Ready arrived (or request withdrawn): resume the pipe.
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                ERR: begin
                    state      <= ERR;
                    hz.mem_err <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef STALL_COUNTERS_EN
    // ------------------------------------------------------------------
    // Performance counters: one increment per cycle in which the matching
    // post-priority condition is applied; saturate at all-ones.
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_lw_stalls <= '0;
            perf_mem_wait  <= '0;
            perf_flushes   <= '0;
        end else begin
            if (apply_lw && perf_lw_stalls != CNT_MAX) begin
                perf_lw_stalls <= perf_lw_stalls + CNT_W'(1);
            end
            if (mem_stall && perf_mem_wait != CNT_MAX) begin
                perf_mem_wait <= perf_mem_wait + CNT_W'(1);
            end
            if (apply_branch && perf_flushes != CNT_MAX) begin
                perf_flushes <= perf_flushes + CNT_W'(1);
            end
        end
    end
`endif

endmodule
